ps2_host_tx: RTL

- Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) from the FPGA to the keyboard.
- Implements the host request-to-send sequence, bit shifting on device-generated clock edges, odd parity, stop bit and device acknowledge check.
- Sits beside the PS/2 receiver at top level. The top level converts the drive-low outputs into open-collector PS2_CLK/PS2_DAT and uses tx_busy to discard receiver output while a send is in progress.

---
 rtl/ps2_host_tx.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, bit shifting on device clock
// edges, odd parity, stop bit and acknowledge check for one command byte.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES   = 6000,
  parameter int REQ_SETUP_CYCLES = 50,
  parameter int START_TIMEOUT    = 750000,
  parameter int FRAME_TIMEOUT    = 100000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       PS2_CLK_IN,
  input  logic       PS2_DAT_IN,
  output logic       ps2_clk_drive_low,
  output logic       ps2_dat_drive_low,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic [1:0] err_code
);

  localparam int IR_MAX    = (INHIBIT_CYCLES > REQ_SETUP_CYCLES) ? INHIBIT_CYCLES : REQ_SETUP_CYCLES;
  localparam int PHASE_MAX = (IR_MAX > START_TIMEOUT) ? IR_MAX : START_TIMEOUT;
  localparam int PW        = $clog2(PHASE_MAX + 1);
  localparam int FW        = $clog2(FRAME_TIMEOUT + 1);

  localparam logic [PW-1:0] INHIBIT_LAST = PW'(INHIBIT_CYCLES - 1);
  localparam logic [PW-1:0] REQ_LAST     = PW'(REQ_SETUP_CYCLES - 1);
  localparam logic [PW-1:0] START_LAST   = PW'(START_TIMEOUT - 1);
  localparam logic [PW-1:0] PHASE_SAT    = PW'(PHASE_MAX);
  localparam logic [FW-1:0] FRAME_LAST   = FW'(FRAME_TIMEOUT - 1);
  localparam logic [FW-1:0] FRAME_SAT    = FW'(FRAME_TIMEOUT);
  localparam logic [3:0]    LAST_BIT     = 4'd9;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_START = 2'b01;
  localparam logic [1:0] ERR_FRAME = 2'b10;
  localparam logic [1:0] ERR_ACK   = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_WAIT_FIRST, S_SHIFT,
    S_WAIT_ACK, S_WAIT_IDLE, S_DONE, S_ERROR
  } state_t;

  state_t        state, state_n;
  logic [1:0]    err_sel;
  logic          clk_meta, clk_sync, clk_prev, dat_meta, dat_sync;
  logic          falling_edge, accept, in_frame;
  logic          start_last, frame_last;
  logic [PW-1:0] phase_timer;
  logic [FW-1:0] frame_timer;
  logic [8:0]    shift_reg;   // {parity, data}; bit 0 is the bit on the wire
  logic [3:0]    bit_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; synchronizers reset to the idle-high bus level so leaving
  // reset never looks like a falling clock edge.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      clk_meta <= 1'b1;
      clk_sync <= 1'b1;
      clk_prev <= 1'b1;
      dat_meta <= 1'b1;
      dat_sync <= 1'b1;
    end else begin
      clk_meta <= PS2_CLK_IN;
      clk_sync <= clk_meta;
      clk_prev <= clk_sync;
      dat_meta <= PS2_DAT_IN;
      dat_sync <= dat_meta;
    end
  end

  assign falling_edge = clk_prev & ~clk_sync;
  assign accept       = tx_valid & (state == S_IDLE);
  assign in_frame     = (state == S_SHIFT) || (state == S_WAIT_ACK) || (state == S_WAIT_IDLE);
  assign start_last   = (phase_timer == START_LAST);
  assign frame_last   = (frame_timer == FRAME_LAST);

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_n;
  end

  // A device edge always wins over a timer expiring in the same cycle.
  always_comb begin
    state_n = state;
    err_sel = ERR_NONE;
    case (state)
      S_IDLE:       if (accept) state_n = S_INHIBIT;
      S_INHIBIT:    if (phase_timer == INHIBIT_LAST) state_n = S_REQ;
      S_REQ:        if (phase_timer == REQ_LAST) state_n = S_WAIT_FIRST;
      S_WAIT_FIRST: begin
        if (falling_edge) begin
          state_n = S_SHIFT;
        end else if (start_last) begin
          state_n = S_ERROR;
          err_sel = ERR_START;
        end
      end
      S_SHIFT: begin
        if (falling_edge) begin
          if (bit_cnt == LAST_BIT) state_n = S_WAIT_ACK;
        end else if (frame_last) begin
          state_n = S_ERROR;
          err_sel = ERR_FRAME;
        end
      end
      S_WAIT_ACK: begin
        if (falling_edge) begin
          if (dat_sync) begin
            state_n = S_ERROR;
            err_sel = ERR_ACK;
          end else begin
            state_n = S_WAIT_IDLE;
          end
        end else if (frame_last) begin
          state_n = S_ERROR;
          err_sel = ERR_FRAME;
        end
      end
      S_WAIT_IDLE: begin
        if (clk_sync && dat_sync) begin
          state_n = S_DONE;
        end else if (frame_last) begin
          state_n = S_ERROR;
          err_sel = ERR_FRAME;
        end
      end
      S_DONE:  state_n = S_IDLE;
      S_ERROR: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      phase_timer <= '0;
      frame_timer <= '0;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      err_code    <= ERR_NONE;
    end else begin
      if (state_n != state)            phase_timer <= '0;
      else if (phase_timer != PHASE_SAT) phase_timer <= phase_timer + 1'b1;

      if (state == S_WAIT_FIRST)                   frame_timer <= '0;
      else if (in_frame && frame_timer != FRAME_SAT) frame_timer <= frame_timer + 1'b1;

      if (accept) begin
        shift_reg <= {~^tx_data, tx_data};
        bit_cnt   <= '0;
        err_code  <= ERR_NONE;
      end else if (state == S_WAIT_FIRST && falling_edge) begin
        bit_cnt <= 4'd1;
      end else if (state == S_SHIFT && falling_edge && bit_cnt != LAST_BIT) begin
        shift_reg <= {1'b1, shift_reg[8:1]};
        bit_cnt   <= bit_cnt + 1'b1;
      end

      if (state_n == S_ERROR && state != S_ERROR) err_code <= err_sel;
    end
  end

  // NOTE: both drives get a default before the case so no latch is inferred.
  always_comb begin
    ps2_clk_drive_low = 1'b0;
    ps2_dat_drive_low = 1'b0;
    case (state)
      S_INHIBIT:    ps2_clk_drive_low = 1'b1;
      S_REQ: begin
        ps2_clk_drive_low = 1'b1;
        ps2_dat_drive_low = 1'b1;
      end
      S_WAIT_FIRST: ps2_dat_drive_low = 1'b1;
      S_SHIFT:      ps2_dat_drive_low = ~shift_reg[0];
      default:      ;
    endcase
  end

  assign tx_ready = (state == S_IDLE);
  assign tx_busy  = ~tx_ready;
  assign tx_done  = (state == S_DONE);
  assign tx_error = (state == S_ERROR);

endmodule
